// File: rtl/reg_a_if.sv
// Operand-A register bus: register-file read data in, registered operand out.
// The master drives data_input and observes data_output; the slave is the register.
interface reg_a_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_input;
  logic [WIDTH-1:0] data_output;

  modport master (
    output data_input,
    input  data_output
  );

  modport slave (
    input  data_input,
    output data_output
  );
endinterface : reg_a_if

// File: rtl/reg_a.sv
// A-operand holding register for the multicycle datapath: plain D register,
// loads every rising edge, asynchronously cleared to RESET_VALUE.
module reg_a #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  reg_a_if.slave bus
);

  logic [WIDTH-1:0] a_q;

  // NOTE: non-blocking assignment so every reader sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= RESET_VALUE;
    end else begin
      a_q <= bus.data_input;
    end
  end

  // Output comes straight from the flop; no combinational path from data_input.
  assign bus.data_output = a_q;

endmodule : reg_a

// File: tb/tb_reg_a.sv
// Self-checking bench for reg_a: expected outputs are queued as stimulus is
// applied and popped when the register output is sampled.
module tb_reg_a;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  reg_a_if #(.WIDTH(WIDTH)) bus ();

  reg_a #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ('0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 20 ns period, rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pop the oldest expected value and compare it with the current output.
  task automatic expect_out(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got %h", tag, bus.data_output);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.data_output, e);
    end
  endtask

  // Apply a value on the falling edge; it must appear one rising edge later.
  task automatic load_cycle(input string tag, input logic [WIDTH-1:0] val);
    @(negedge clk);
    bus.data_input = val;
    exp_q.push_back(val);
    @(posedge clk);
    #1;
    expect_out(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.data_input = 32'hFFFF_FFFF;

    // Reset holds the output at zero regardless of clock edges.
    #1;
    exp_q.push_back('0);
    expect_out("reset_initial");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back('0);
      expect_out($sformatf("reset_edge%0d", i));
    end

    // Releasing reset between edges is not a load.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back('0);
    expect_out("release_no_load");

    load_cycle("capture_1", 32'd1);
    load_cycle("capture_2", 32'd2);
    load_cycle("capture_3", 32'd3);

    // Glitch the input during the high phase; output must not move.
    bus.data_input = 32'hA5A5_A5A5;
    #3;
    exp_q.push_back(32'd3);
    expect_out("hold_glitch_hi");
    bus.data_input = 32'd3;
    #3;
    exp_q.push_back(32'd3);
    expect_out("hold_glitch_back");
    exp_q.push_back(32'd3);
    @(posedge clk);
    #1;
    expect_out("hold_next_edge");

    load_cycle("full_width_msb_lsb", 32'h8000_0001);
    load_cycle("full_width_inverse", 32'h7FFF_FFFE);

    // Asynchronous clear mid-run, between edges.
    load_cycle("pre_async", 32'h1234_5678);
    @(negedge clk);
    bus.data_input = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    expect_out("async_clear_immediate");
    #2;
    rst_n = 1'b1;
    #1;
    exp_q.push_back('0);
    expect_out("async_release_no_load");
    exp_q.push_back(32'hCAFE_F00D);
    @(posedge clk);
    #1;
    expect_out("async_reload");

    // Deassert exactly on a rising edge: that edge must not load. The
    // non-blocking update lands after the flop has evaluated the edge.
    @(negedge clk);
    rst_n = 1'b0;
    bus.data_input = 32'h55AA_55AA;
    #1;
    exp_q.push_back('0);
    expect_out("coincident_pre");
    @(posedge clk);
    rst_n <= 1'b1;
    #1;
    exp_q.push_back('0);
    expect_out("coincident_edge_no_load");
    exp_q.push_back(32'h55AA_55AA);
    @(posedge clk);
    #1;
    expect_out("coincident_following_edge");

    load_cycle("final_capture", 32'h0F0F_F0F0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reg_a

// File: doc/reg_a.md
Name: reg_a

Overview:
- 32-bit pipeline holding register for the A operand in the multicycle datapath (Proyecto4).
- Captures the register-file read-port-A value on every rising clock edge and presents it to the ALU-side muxes during the following cycle.
- No enable and no bypass: a pure edge-triggered D register with asynchronous active-low clear.

Parameters:
- WIDTH, 32, data width of data_input/data_output.
- RESET_VALUE, 0 (WIDTH bits), value forced onto data_output while reset is asserted.

Ports:
- clk  input  1  system clock; all state changes on rising edge except reset.
- rst_n  input  1  asynchronous active-low reset.
- data_input  input  WIDTH  value to capture (register-file read data A).
- data_output  output  WIDTH  registered copy of data_input.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - rst_n low forces data_output = RESET_VALUE immediately, independent of clk.
  - Held while rst_n is low; clock edges are ignored.
- Deassertion:
  - rst_n rising is not itself a load.
  - The first capture occurs on the first rising clk edge with rst_n high.
  - An edge coincident with deassertion does not load.
- Capture:
  - On each rising clk edge with rst_n high, data_output <= data_input sampled just before the edge.
  - Latency is exactly one cycle.
  - Loads every cycle; there is no hold mode.
- Between edges:
  - data_output is stable.
  - data_input glitches or changes between edges have no effect on the output.
- Width: all WIDTH bits transfer unmodified; no sign extension, truncation or arithmetic.
- Uninitialised operation: if rst_n is never asserted, data_output is X until the first rising edge, then follows the capture rule.
- Reset mid-operation: assertion at any time clears data_output asynchronously, overriding a same-instant clock edge.
- Simultaneous input change and clock edge:
  - The register takes the pre-edge value (nonblocking semantics).
  - Benches must change data_input away from rising edges, e.g. on falling edges.
- Implementation: single always block sensitive to posedge clk and negedge rst_n; output driven directly from the flop (registered output, no combinational path from data_input).

Test Plan:
- Reset: clk 20 ns period; rst_n=0 with data_input=32'hFFFF_FFFF, toggle clk 3 cycles -> data_output stays 0 throughout.
- Basic capture: release rst_n, then on falling edges drive data_input 1, 2, 3 -> data_output reads 1, 2, 3 on the three successive rising edges, each exactly one cycle after the input was applied.
- Hold between edges: change data_input from 3 to 32'hA5A5_A5A5 and back to 3 within one clk-high phase -> data_output unchanged until the next rising edge, then 3.
- Full-width pattern: data_input = 32'h8000_0001, then 32'h7FFF_FFFE -> data_output matches bit-exactly on successive edges (MSB/LSB toggling, no sign effects).
- Async reset mid-run: with data_output=32'h1234_5678, pulse rst_n low for 3 ns between edges -> data_output becomes 0 immediately, not at the next edge. On the next edge after release, it loads the current data_input.
- Reset release timing: deassert rst_n coincident with a rising edge -> no load on that edge; output remains 0 until the following edge.
